md_mode_buf: RTL and testbench

//  Ping-pong buffer downstream of the intra mode-decision top for one 64x64 LCU.
//  It captures the per-block best modes (8x8, 16x16 and 32x32) as the decision

---
 rtl/md_pkg.sv | 39 +++
 rtl/md_mode_buf_if.sv | 34 +++
 rtl/md_mode_bank.sv | 41 ++++
 rtl/md_mode_buf.sv | 120 ++++++++++++
 tb/tb_md_mode_buf.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared constants for the intra mode-decision buffer: mode code range,
// block-size encodings, per-LCU entry counts and the bank address map.
package md_pkg;

  localparam int MODE_W = 6;
  localparam int N8     = 64;
  localparam int N16    = 16;
  localparam int N32    = 4;
  localparam int DEPTH  = N8 + N16 + N32;

  localparam logic [MODE_W-1:0] PLANAR  = 6'd0;
  localparam logic [MODE_W-1:0] DC      = 6'd1;
  localparam logic [MODE_W-1:0] ANG_MAX = 6'd34;

  localparam logic [6:0] N8_CNT  = 7'(N8);
  localparam logic [4:0] N16_CNT = 5'(N16);
  localparam logic [2:0] N32_CNT = 3'(N32);

  typedef enum logic [1:0] {
    SZ8    = 2'd0,
    SZ16   = 2'd1,
    SZ32   = 2'd2,
    SZ_RSV = 2'd3
  } size_e;

  // One bank holds the 8x8 entries first, then 16x16, then 32x32.
  function automatic logic [6:0] bank_addr(size_e sz, logic [5:0] idx);
    logic [6:0] a;
    a = '0;
    case (sz)
      SZ8:     a = {1'b0, idx};
      SZ16:    a = 7'(N8) + {3'b000, idx[3:0]};
      SZ32:    a = 7'(N8 + N16) + {5'b00000, idx[1:0]};
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/md_mode_buf_if.sv
// Producer/consumer bus of the mode buffer: three mode write strobes plus
// commit on the producer side, random-access read plus release on the consumer side.
interface md_mode_buf_if;
  import md_pkg::*;

  logic              wr_vld8;
  logic [MODE_W-1:0] wr_mode8;
  logic              wr_vld16;
  logic [MODE_W-1:0] wr_mode16;
  logic              wr_vld32;
  logic [MODE_W-1:0] wr_mode32;
  logic              md_finish;
  logic              wr_ready;
  logic              rd_bank_vld;
  logic              rd_en;
  logic [1:0]        rd_size;
  logic [5:0]        rd_idx;
  logic [MODE_W-1:0] rd_mode;
  logic              rd_done;
  logic              err_o;

  modport master (
    output wr_vld8, wr_mode8, wr_vld16, wr_mode16, wr_vld32, wr_mode32,
    output md_finish, rd_en, rd_size, rd_idx, rd_done,
    input  wr_ready, rd_bank_vld, rd_mode, err_o
  );

  modport slave (
    input  wr_vld8, wr_mode8, wr_vld16, wr_mode16, wr_vld32, wr_mode32,
    input  md_finish, rd_en, rd_size, rd_idx, rd_done,
    output wr_ready, rd_bank_vld, rd_mode, err_o
  );

endinterface

// File: rtl/md_mode_bank.sv
// One LCU worth of best modes (64 + 16 + 4 entries): three independent write
// ports into disjoint regions and one registered read port.
module md_mode_bank
  import md_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              we8,
  input  logic [5:0]        wa8,
  input  logic [MODE_W-1:0] wd8,
  input  logic              we16,
  input  logic [3:0]        wa16,
  input  logic [MODE_W-1:0] wd16,
  input  logic              we32,
  input  logic [1:0]        wa32,
  input  logic [MODE_W-1:0] wd32,
  input  logic              re,
  input  size_e             rsize,
  input  logic [5:0]        ridx,
  output logic [MODE_W-1:0] rdata
);

  logic [MODE_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset so it maps onto plain RAM/register-file cells;
  // only the read register and the control state in the top are reset.
  always_ff @(posedge clk) begin
    if (we8)  mem[bank_addr(SZ8,  wa8)]          <= wd8;
    if (we16) mem[bank_addr(SZ16, {2'b00, wa16})] <= wd16;
    if (we32) mem[bank_addr(SZ32, {4'b0000, wa32})] <= wd32;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (rsize == SZ_RSV) ? '0 : mem[bank_addr(rsize, ridx)];
    end
  end

endmodule

// File: rtl/md_mode_buf.sv
// Ping-pong buffer of per-block best intra modes for one 64x64 LCU.
// Optional checker built when MD_MODE_CHK_EN is defined (drives err_o).
module md_mode_buf
  import md_pkg::*;
(
  input logic         clk,
  input logic         rstn,
  md_mode_buf_if.slave bus
);

  logic [1:0]        full;
  logic              wb;
  logic              rb;
  logic              rd_sel;
  logic [6:0]        cnt8;
  logic [4:0]        cnt16;
  logic [2:0]        cnt32;
  logic              acc8, acc16, acc32;
  logic              fin_ok, rel_ok;
  logic [MODE_W-1:0] q [2];

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    acc8   = 1'b0;
    acc16  = 1'b0;
    acc32  = 1'b0;
    acc8   = bus.wr_vld8  && !full[wb] && (cnt8  != N8_CNT);
    acc16  = bus.wr_vld16 && !full[wb] && (cnt16 != N16_CNT);
    acc32  = bus.wr_vld32 && !full[wb] && (cnt32 != N32_CNT);
    fin_ok = bus.md_finish && !full[wb];
    rel_ok = bus.rd_done && full[rb];
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // so commit and release in one cycle see the same full/wb/rb snapshot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full   <= 2'b00;
      wb     <= 1'b0;
      rb     <= 1'b0;
      rd_sel <= 1'b0;
      cnt8   <= '0;
      cnt16  <= '0;
      cnt32  <= '0;
    end else begin
      if (fin_ok) begin
        full[wb] <= 1'b1;
        wb       <= ~wb;
        cnt8     <= '0;
        cnt16    <= '0;
        cnt32    <= '0;
      end else begin
        if (acc8)  cnt8  <= cnt8  + 7'd1;
        if (acc16) cnt16 <= cnt16 + 5'd1;
        if (acc32) cnt32 <= cnt32 + 3'd1;
      end
      // A commit and a release in one cycle always target different banks.
      if (rel_ok) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
      end
      if (bus.rd_en) rd_sel <= rb;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BANK = 1'(b);
    md_mode_bank u_bank (
      .clk   (clk),
      .rstn  (rstn),
      .we8   (acc8  && (wb == BANK)),
      .wa8   (cnt8[5:0]),
      .wd8   (bus.wr_mode8),
      .we16  (acc16 && (wb == BANK)),
      .wa16  (cnt16[3:0]),
      .wd16  (bus.wr_mode16),
      .we32  (acc32 && (wb == BANK)),
      .wa32  (cnt32[1:0]),
      .wd32  (bus.wr_mode32),
      .re    (bus.rd_en && (rb == BANK)),
      .rsize (size_e'(bus.rd_size)),
      .ridx  (bus.rd_idx),
      .rdata (q[b])
    );
  end

  assign bus.wr_ready    = ~full[wb];
  assign bus.rd_bank_vld = full[rb];
  assign bus.rd_mode     = q[rd_sel];

`ifdef MD_MODE_CHK_EN
  logic err_q;
  logic err_set;

  always_comb begin
    err_set = 1'b0;
    err_set = (bus.wr_vld8  && !acc8)
           || (bus.wr_vld16 && !acc16)
           || (bus.wr_vld32 && !acc32)
           || (bus.md_finish && ((cnt8 != N8_CNT) || (cnt16 != N16_CNT) || (cnt32 != N32_CNT)))
           || (bus.md_finish && full[wb])
           || (bus.rd_en && !full[rb])
           || (bus.rd_en && (size_e'(bus.rd_size) == SZ_RSV))
           || (bus.wr_vld8  && (bus.wr_mode8  > ANG_MAX))
           || (bus.wr_vld16 && (bus.wr_mode16 > ANG_MAX))
           || (bus.wr_vld32 && (bus.wr_mode32 > ANG_MAX));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_q | err_set;
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_md_mode_buf.sv
// Scoreboard bench for md_mode_buf: reads push expected modes into a queue,
// a monitor compares rd_mode one cycle after each accepted rd_en.
module tb_md_mode_buf;
  import md_pkg::*;

`ifdef MD_MODE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic rstn;
  md_mode_buf_if bus ();

  md_mode_buf dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [MODE_W-1:0] exp_q [$];
  string             nm_q  [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: rd_mode is valid half a cycle after the edge that sampled rd_en.
  initial begin
    forever begin
      @(posedge clk);
      if (bus.rd_en === 1'b1) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rd_unexpected: got %0d, expected no read", bus.rd_mode);
        end else begin
          check(nm_q.pop_front(), 32'(bus.rd_mode), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.wr_vld8 = 0; bus.wr_mode8 = '0;
    bus.wr_vld16 = 0; bus.wr_mode16 = '0;
    bus.wr_vld32 = 0; bus.wr_mode32 = '0;
    bus.md_finish = 0; bus.rd_en = 0; bus.rd_size = '0; bus.rd_idx = '0;
    bus.rd_done = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic fill(int n8, int n16, int n32, int base);
    for (int i = 0; i < n8; i++) begin
      bus.wr_vld8   = 1'b1;
      bus.wr_mode8  = MODE_W'((i + base) % 35);
      bus.wr_vld16  = (i < n16);
      bus.wr_mode16 = MODE_W'((i + base) % 35);
      bus.wr_vld32  = (i < n32);
      bus.wr_mode32 = MODE_W'((i + base) % 35);
      @(negedge clk);
    end
    bus.wr_vld8 = 0; bus.wr_vld16 = 0; bus.wr_vld32 = 0;
  endtask

  task automatic finish();
    bus.md_finish = 1'b1;
    @(negedge clk);
    bus.md_finish = 1'b0;
  endtask

  task automatic release_bank();
    bus.rd_done = 1'b1;
    @(negedge clk);
    bus.rd_done = 1'b0;
  endtask

  task automatic rd(logic [1:0] sz, logic [5:0] idx, logic [MODE_W-1:0] exp, string nm);
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    bus.rd_en = 1'b1; bus.rd_size = sz; bus.rd_idx = idx;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL rd_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
      nm_q.delete();
    end
  endtask

  initial begin
    do_reset();
    check("rst_wr_ready", 32'(bus.wr_ready), 1);
    check("rst_rd_bank_vld", 32'(bus.rd_bank_vld), 0);
    check("rst_rd_mode", 32'(bus.rd_mode), 0);
    check("rst_err", 32'(bus.err_o), 0);

    // 1: full LCU, commit, read back
    fill(64, 16, 4, 0);
    check("t1_vld_before_commit", 32'(bus.rd_bank_vld), 0);
    finish();
    check("t1_rd_bank_vld", 32'(bus.rd_bank_vld), 1);
    check("t1_wr_ready", 32'(bus.wr_ready), 1);
    rd(2'd0, 6'd37, 6'd2, "t1_rd8_37");
    rd(2'd1, 6'd15, 6'd15, "t1_rd16_15");
    rd(2'd2, 6'd3, 6'd3, "t1_rd32_3");
    rd(2'd0, 6'd63, 6'd28, "t1_rd8_63");
    rd(2'd1, 6'd52, 6'd4, "t1_rd16_mask");
    drain();
    check("t1_err", 32'(bus.err_o), 0);
    release_bank();
    check("t1_vld_after_done", 32'(bus.rd_bank_vld), 0);

    // 2: both banks full, third commit ignored
    fill(64, 16, 4, 5);
    finish();
    fill(64, 16, 4, 10);
    finish();
    check("t2_wr_ready_full", 32'(bus.wr_ready), 0);
    check("t2_err_before", 32'(bus.err_o), 0);
    rd(2'd0, 6'd0, 6'd5, "t2_rdA_0");
    drain();
    finish();
    check("t2_err_ignored_fin", 32'(bus.err_o), 32'(CHK));
    check("t2_wr_ready_still0", 32'(bus.wr_ready), 0);
    release_bank();
    check("t2_wr_ready_after_done", 32'(bus.wr_ready), 1);
    check("t2_vld_B", 32'(bus.rd_bank_vld), 1);
    rd(2'd0, 6'd0, 6'd10, "t2_rdB_0");
    rd(2'd1, 6'd15, 6'd25, "t2_rdB16_15");
    drain();
    release_bank();

    // 3: 65 8x8 writes, the last one dropped
    do_reset();
    fill(64, 0, 0, 0);
    check("t3_err_at_64", 32'(bus.err_o), 0);
    bus.wr_vld8 = 1'b1; bus.wr_mode8 = 6'd33;
    @(negedge clk);
    bus.wr_vld8 = 1'b0;
    check("t3_err_dropped", 32'(bus.err_o), 32'(CHK));
    finish();
    rd(2'd0, 6'd63, 6'd28, "t3_rd8_63_kept");
    rd(2'd0, 6'd0, 6'd0, "t3_rd8_0");
    drain();
    release_bank();

    // 4: last writes coincide with commit
    do_reset();
    fill(63, 15, 3, 0);
    bus.wr_vld8 = 1; bus.wr_mode8 = 6'd34;
    bus.wr_vld16 = 1; bus.wr_mode16 = 6'd33;
    bus.wr_vld32 = 1; bus.wr_mode32 = 6'd32;
    bus.md_finish = 1;
    @(negedge clk);
    idle_inputs();
    check("t4_vld", 32'(bus.rd_bank_vld), 1);
    check("t4_wr_ready", 32'(bus.wr_ready), 1);
    rd(2'd0, 6'd63, 6'd34, "t4_rd8_63");
    rd(2'd1, 6'd15, 6'd33, "t4_rd16_15");
    rd(2'd2, 6'd3, 6'd32, "t4_rd32_3");
    rd(2'd0, 6'd62, 6'd27, "t4_rd8_62");
    drain();

    // 5: release bank 0 while committing bank 1 (counters restarted at 0)
    bus.wr_vld8 = 1; bus.wr_mode8 = 6'd9;
    bus.wr_vld16 = 1; bus.wr_mode16 = 6'd8;
    bus.wr_vld32 = 1; bus.wr_mode32 = 6'd7;
    @(negedge clk);
    idle_inputs();
    bus.rd_done = 1; bus.md_finish = 1;
    @(negedge clk);
    idle_inputs();
    check("t5_wr_ready_wb0", 32'(bus.wr_ready), 1);
    check("t5_vld_rb1", 32'(bus.rd_bank_vld), 1);
    rd(2'd3, 6'd5, 6'd0, "t5_rd_rsv");
    rd(2'd0, 6'd0, 6'd9, "t5_rd8_0");
    rd(2'd1, 6'd0, 6'd8, "t5_rd16_0");
    rd(2'd2, 6'd0, 6'd7, "t5_rd32_0");
    drain();
    check("t5_err_rsv", 32'(bus.err_o), 32'(CHK));
    finish();
    check("t5_wr_ready_both_full", 32'(bus.wr_ready), 0);
    release_bank();
    check("t5_vld_bank0", 32'(bus.rd_bank_vld), 1);

    // 6: asynchronous reset mid-write with one bank full
    bus.wr_vld8 = 1; bus.wr_mode8 = 6'd3;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_vld_async", 32'(bus.rd_bank_vld), 0);
    check("t6_wr_ready_async", 32'(bus.wr_ready), 1);
    check("t6_rd_mode_async", 32'(bus.rd_mode), 0);
    check("t6_err_async", 32'(bus.err_o), 0);
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
    bus.wr_vld8 = 1; bus.wr_mode8 = 6'd21;
    @(negedge clk);
    bus.wr_vld8 = 0;
    finish();
    rd(2'd0, 6'd0, 6'd21, "t6_restart_entry0");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
